alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_ctrl_dec.sv | 42 ++++
 rtl/alu_issue.sv | 102 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_issue shared constants: ALU control codes, ALUOp, R-type funct, FSM states.
// Used by the decoder, the issue stage and the bench.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ILL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue bus: decode-side handshake, ALU drive/response, downstream handshake.
// slave is the issue block; master is its surroundings.
interface alu_issue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [5:0]       in_funct;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_aluop, in_funct, in_a, in_b,
    input  alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_control,
    output out_valid, out_result, out_zero, out_illegal
  );

  modport master (
    output in_valid, in_aluop, in_funct, in_a, in_b,
    output alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_control,
    input  out_valid, out_result, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct -> ALU control decoder.
// Unknown encodings map to ALU_ILL and raise illegal.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] control,
  output logic       illegal
);

  always_comb begin
    control = ALU_ILL;
    illegal = 1'b1;
    unique case (1'b1)
      (aluop == ALUOP_MEM): begin
        control = ALU_ADD;
        illegal = 1'b0;
      end
      (aluop == ALUOP_BEQ): begin
        control = ALU_SUB;
        illegal = 1'b0;
      end
      (aluop == ALUOP_RTYPE): begin
        illegal = 1'b0;
        unique case (1'b1)
          (funct == FN_ADD): control = ALU_ADD;
          (funct == FN_SUB): control = ALU_SUB;
          (funct == FN_AND): control = ALU_AND;
          (funct == FN_OR):  control = ALU_OR;
          (funct == FN_SLT): control = ALU_SLT;
          default: begin
            control = ALU_ILL;
            illegal = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: IDLE/EXEC/DONE sequencer around an external ALU.
// Define ALU_ISSUE_ILLEGAL_TRAP_EN to flag illegal ops and zero their result.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  alu_issue_if.slave bus
);

  state_t     state;
  logic       accept;
  logic [2:0] dec_ctrl;
  logic       dec_ill;

  alu_ctrl_dec u_dec (
    .aluop   (bus.in_aluop),
    .funct   (bus.in_funct),
    .control (dec_ctrl),
    .illegal (dec_ill)
  );

  assign bus.in_ready = !reset && !flush &&
    ((state == ST_IDLE) ||
     ((state == ST_DONE) && bus.out_ready));

  assign accept = bus.in_valid && bus.in_ready;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic ill_op;
  logic ill_q;

  assign bus.out_illegal = ill_q;
`else
  logic unused_ill;

  assign unused_ill      = dec_ill;
  assign bus.out_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bus.out_valid   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_zero    <= 1'b0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_control <= ALU_ADD;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      ill_op          <= 1'b0;
      ill_q           <= 1'b0;
`endif
    end else if (flush) begin
      state         <= ST_IDLE;
      bus.out_valid <= 1'b0;
    end else begin
      // accept is only possible in IDLE or in DONE while retiring
      if (accept) begin
        bus.alu_a       <= bus.in_a;
        bus.alu_b       <= bus.in_b;
        bus.alu_control <= dec_ctrl;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        ill_op          <= dec_ill;
`endif
      end
      unique case (state)
        ST_IDLE: begin
          if (accept) state <= ST_EXEC;
        end
        ST_EXEC: begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
          ill_q <= ill_op;
          if (ill_op) begin
            bus.out_result <= '0;
            bus.out_zero   <= 1'b1;
          end else begin
            bus.out_result <= bus.alu_result;
            bus.out_zero   <= bus.alu_zero;
          end
`else
          bus.out_result <= bus.alu_result;
          bus.out_zero   <= bus.alu_zero;
`endif
          bus.out_valid <= 1'b1;
          state         <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
